// File: rtl/pb_uart_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pb_uart_regs_pkg
// Purpose  : Shared register map, IRQ bit indices and STATUS layout for the
//            multi-channel PicoBlaze UART register front end.
// Revision : 1.0  initial release
// ============================================================================
package pb_uart_regs_pkg;

  // Each channel owns an 8-port window
  localparam int CHAN_STRIDE = 8;

  // Register offsets inside a channel window
  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_STATUS   = 3'd2,
    REG_IRQ_MASK = 3'd3,
    REG_IRQ_PEND = 3'd4,
    REG_DIV_LO   = 3'd5,
    REG_DIV_HI   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_ofs_e;

  // Interrupt source bit indices within IRQ_MASK / IRQ_PEND
  localparam int IRQ_RX_DATA  = 0;
  localparam int IRQ_RX_FULL  = 1;
  localparam int IRQ_TX_EMPTY = 2;
  localparam int IRQ_TX_OVF   = 3;
  localparam int IRQ_W        = 4;

  // STATUS register bit positions
  localparam int ST_RX_DATA  = 0;
  localparam int ST_RX_HALF  = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_TX_DATA  = 3;
  localparam int ST_TX_HALF  = 4;
  localparam int ST_TX_FULL  = 5;

  // FIFO flags of one channel
  typedef struct packed {
    logic tx_full;
    logic tx_half_full;
    logic tx_data_present;
    logic rx_full;
    logic rx_half_full;
    logic rx_data_present;
  } uart_flags_t;

  // Build the STATUS read value from the live FIFO flags
  function automatic logic [7:0] status_byte(input uart_flags_t f);
    logic [7:0] s;
    s             = 8'h00;
    s[ST_RX_DATA] = f.rx_data_present;
    s[ST_RX_HALF] = f.rx_half_full;
    s[ST_RX_FULL] = f.rx_full;
    s[ST_TX_DATA] = f.tx_data_present;
    s[ST_TX_HALF] = f.tx_half_full;
    s[ST_TX_FULL] = f.tx_full;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pb_uart_regs_chan.sv
`default_nettype none
// ============================================================================
// Module   : pb_uart_regs_chan
// Purpose  : One channel's register window: CONTROL, IRQ mask/pending with
//            W1C, divisor shadow/commit, flag edge detection and one-shot
//            FIFO push/pop pulses.
// Revision : 1.0  initial release
// ============================================================================
module pb_uart_regs_chan
  import pb_uart_regs_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_i,
  input  reg_ofs_e    offset_i,
  input  logic [7:0]  data_in_i,
  input  logic        read_strobe_i,
  input  logic        write_strobe_i,
  input  uart_flags_t flags_i,
  input  logic [7:0]  rx_data_i,
  output logic        buffer_write_o,
  output logic        buffer_read_o,
  output logic        enable_o,
  output logic [15:0] div_o,
  output logic [7:0]  rd_data_o,
  output logic        irq_o
);

  logic [7:0]       control_q, control_d;
  logic [IRQ_W-1:0] mask_q, mask_d;
  logic [IRQ_W-1:0] pend_q, pend_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [15:0]      div_q, div_d;
  uart_flags_t      flags_q;
  logic             armed_q;
  logic             wr_data_q;
  logic             rd_data_q;
  logic             buffer_write_q;
  logic             buffer_read_q;

  logic             w_wr;
  logic             w_wr_data;
  logic             w_rd_data;
  logic             w_wr_rise;
  logic             w_rd_rise;
  logic [IRQ_W-1:0] w_evt;
  logic [IRQ_W-1:0] w_clr;

  // Strobes qualified by this window; DATA accesses are edge-qualified so a
  // held strobe yields a single FIFO push or pop.
  assign w_wr      = sel_i & write_strobe_i;
  assign w_wr_data = w_wr & (offset_i == REG_DATA);
  assign w_rd_data = sel_i & read_strobe_i & (offset_i == REG_DATA);
  assign w_wr_rise = w_wr_data & ~wr_data_q;
  assign w_rd_rise = w_rd_data & ~rd_data_q;

  // Interrupt events; flag edges are suppressed until the edge registers
  // have captured the flags once after reset.
  always_comb begin
    w_evt               = '0;
    w_evt[IRQ_RX_DATA]  = armed_q & flags_i.rx_data_present & ~flags_q.rx_data_present;
    w_evt[IRQ_RX_FULL]  = armed_q & flags_i.rx_full & ~flags_q.rx_full;
    w_evt[IRQ_TX_EMPTY] = armed_q & ~flags_i.tx_data_present & flags_q.tx_data_present;
    w_evt[IRQ_TX_OVF]   = w_wr_rise & flags_i.tx_full;
  end

  // Write decode into next-state values; a new event beats a W1C clear.
  always_comb begin
    control_d = control_q;
    mask_d    = mask_q;
    shadow_d  = shadow_q;
    div_d     = div_q;
    w_clr     = '0;
    if (w_wr) begin
      case (offset_i)
        REG_CONTROL:  control_d = data_in_i;
        REG_IRQ_MASK: mask_d    = data_in_i[IRQ_W-1:0];
        REG_IRQ_PEND: w_clr     = data_in_i[IRQ_W-1:0];
        REG_DIV_LO:   shadow_d  = data_in_i;
        REG_DIV_HI:   div_d     = {data_in_i, shadow_q};
        default:      ;
      endcase
    end
    pend_d = (pend_q & ~w_clr) | w_evt;
  end

  // Read value for the currently addressed offset
  always_comb begin
    rd_data_o = 8'h00;
    case (offset_i)
      REG_DATA:     rd_data_o = rx_data_i;
      REG_CONTROL:  rd_data_o = control_q;
      REG_STATUS:   rd_data_o = status_byte(flags_i);
      REG_IRQ_MASK: rd_data_o = {{(8-IRQ_W){1'b0}}, mask_q};
      REG_IRQ_PEND: rd_data_o = {{(8-IRQ_W){1'b0}}, pend_q};
      REG_DIV_LO:   rd_data_o = shadow_q;
      REG_DIV_HI:   rd_data_o = div_q[15:8];
      REG_RSVD:     rd_data_o = 8'h00;
    endcase
  end

  // Channel state registers and one-cycle FIFO pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      control_q      <= 8'h00;
      mask_q         <= '0;
      pend_q         <= '0;
      shadow_q       <= 8'h00;
      div_q          <= DIV_RESET;
      flags_q        <= '0;
      armed_q        <= 1'b0;
      wr_data_q      <= 1'b0;
      rd_data_q      <= 1'b0;
      buffer_write_q <= 1'b0;
      buffer_read_q  <= 1'b0;
    end else begin
      control_q      <= control_d;
      mask_q         <= mask_d;
      pend_q         <= pend_d;
      shadow_q       <= shadow_d;
      div_q          <= div_d;
      flags_q        <= flags_i;
      armed_q        <= 1'b1;
      wr_data_q      <= w_wr_data;
      rd_data_q      <= w_rd_data;
      buffer_write_q <= w_wr_rise & ~flags_i.tx_full;
      buffer_read_q  <= w_rd_rise & flags_i.rx_data_present;
    end
  end

  assign buffer_write_o = buffer_write_q;
  assign buffer_read_o  = buffer_read_q;
  assign enable_o       = control_q[0];
  assign div_o          = div_q;
  assign irq_o          = |(pend_q & mask_q);

endmodule
`default_nettype wire

// File: rtl/pb_uart_regs_mc.sv
`default_nettype none
// ============================================================================
// Module   : pb_uart_regs_mc
// Purpose  : PicoBlaze port-mapped register front end for NUM_CHANNELS
//            UART/FIFO pairs: window decode, registered read mux,
//            IRQ summary port and global interrupt output.
//            BASE_ADDRESS must be a multiple of 8.
// Revision : 1.0  initial release
// ============================================================================
module pb_uart_regs_mc
  import pb_uart_regs_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDRESS = 8'h00,
  parameter int          NUM_CHANNELS = 2,
  parameter logic [15:0] DIV_RESET    = 16'h0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                port_id,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic                      read_strobe,
  input  logic                      write_strobe,
  output logic                      interrupt,
  output logic [NUM_CHANNELS-1:0]   buffer_write,
  output logic [7:0]                uart_data_write,
  output logic [NUM_CHANNELS-1:0]   buffer_read,
  input  logic [8*NUM_CHANNELS-1:0] uart_data_read,
  input  logic [NUM_CHANNELS-1:0]   rx_data_present,
  input  logic [NUM_CHANNELS-1:0]   rx_half_full,
  input  logic [NUM_CHANNELS-1:0]   rx_full,
  input  logic [NUM_CHANNELS-1:0]   tx_data_present,
  input  logic [NUM_CHANNELS-1:0]   tx_half_full,
  input  logic [NUM_CHANNELS-1:0]   tx_full,
  output logic [NUM_CHANNELS-1:0]   enable,
  output logic [16*NUM_CHANNELS-1:0] uart_clock_divide
);

  logic [7:0] data_out_q, data_out_d;
  logic       interrupt_q;
  logic [7:0] uart_data_write_q, uart_data_write_d;

  logic [8:0]              w_rel;
  reg_ofs_e                w_offset;
  logic [NUM_CHANNELS-1:0] w_sel;
  logic [NUM_CHANNELS-1:0] w_irq;
  logic [7:0]              w_rd_data [NUM_CHANNELS];
  logic                    w_summary_sel;
  logic [7:0]              w_summary;
  logic                    w_data_wr;

  // Offset from the base in 9 bits so ports below the base never alias
  assign w_rel         = {1'b0, port_id} - {1'b0, BASE_ADDRESS};
  assign w_offset      = reg_ofs_e'(port_id[2:0]);
  assign w_summary_sel = (w_rel == 9'(CHAN_STRIDE * NUM_CHANNELS));
  assign w_summary     = {{(8-NUM_CHANNELS){1'b0}}, w_irq};
  assign w_data_wr     = write_strobe & (|w_sel) & (w_offset == REG_DATA);

  generate
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      uart_flags_t w_flags;

      assign w_sel[c] = ~w_rel[8] & (w_rel[7:3] == 5'(c));
      assign w_flags  = {tx_full[c], tx_half_full[c], tx_data_present[c],
                         rx_full[c], rx_half_full[c], rx_data_present[c]};

      pb_uart_regs_chan #(
        .DIV_RESET (DIV_RESET)
      ) u_chan (
        .clk            (clk),
        .reset          (reset),
        .sel_i          (w_sel[c]),
        .offset_i       (w_offset),
        .data_in_i      (data_in),
        .read_strobe_i  (read_strobe),
        .write_strobe_i (write_strobe),
        .flags_i        (w_flags),
        .rx_data_i      (uart_data_read[8*c +: 8]),
        .buffer_write_o (buffer_write[c]),
        .buffer_read_o  (buffer_read[c]),
        .enable_o       (enable[c]),
        .div_o          (uart_clock_divide[16*c +: 16]),
        .rd_data_o      (w_rd_data[c]),
        .irq_o          (w_irq[c])
      );
    end
  endgenerate

  // Read mux: addressed channel window, summary port, else zero
  always_comb begin
    data_out_d = 8'h00;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_sel[c]) data_out_d = w_rd_data[c];
    end
    if (w_summary_sel) data_out_d = w_summary;
  end

  // Shared TX data latches on any DATA write, even when the FIFO is full
  always_comb begin
    uart_data_write_d = uart_data_write_q;
    if (w_data_wr) uart_data_write_d = data_in;
  end

  // Output registers: read data every cycle, interrupt summary, TX data
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q        <= 8'h00;
      interrupt_q       <= 1'b0;
      uart_data_write_q <= 8'h00;
    end else begin
      data_out_q        <= data_out_d;
      interrupt_q       <= |w_irq;
      uart_data_write_q <= uart_data_write_d;
    end
  end

  assign data_out        = data_out_q;
  assign interrupt       = interrupt_q;
  assign uart_data_write = uart_data_write_q;

endmodule
`default_nettype wire

// File: tb/tb_pb_uart_regs_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pb_uart_regs_mc
// Purpose  : Scoreboard bench for pb_uart_regs_mc (2 channels, base 0x00).
// Revision : 1.0  initial release
// ============================================================================
module tb_pb_uart_regs_mc;

  localparam int          NCH  = 2;
  localparam logic [15:0] DIVR = 16'hC3A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id, data_in, data_out, uart_data_write;
  logic        read_strobe, write_strobe, interrupt;
  logic [NCH-1:0] buffer_write, buffer_read, enable;
  logic [NCH-1:0] rx_dp, rx_hf, rx_fl, tx_dp, tx_hf, tx_fl;
  logic [8*NCH-1:0]  uart_data_read;
  logic [16*NCH-1:0] uart_clock_divide;

  pb_uart_regs_mc #(
    .BASE_ADDRESS (8'h00),
    .NUM_CHANNELS (NCH),
    .DIV_RESET    (DIVR)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .port_id           (port_id),
    .data_in           (data_in),
    .data_out          (data_out),
    .read_strobe       (read_strobe),
    .write_strobe      (write_strobe),
    .interrupt         (interrupt),
    .buffer_write      (buffer_write),
    .uart_data_write   (uart_data_write),
    .buffer_read       (buffer_read),
    .uart_data_read    (uart_data_read),
    .rx_data_present   (rx_dp),
    .rx_half_full      (rx_hf),
    .rx_full           (rx_fl),
    .tx_data_present   (tx_dp),
    .tx_half_full      (tx_hf),
    .tx_full           (tx_fl),
    .enable            (enable),
    .uart_clock_divide (uart_clock_divide)
  );

  always #5 clk = ~clk;

  // Scoreboard queues
  typedef struct {
    int          kind;   // 0 interrupt, 1 divisor, 2 uart_data_write, 3 enable
    logic [31:0] exp;
  } snap_t;

  logic [7:0] rd_q[$];
  logic [3:0] pulse_q[$];   // {buffer_write, buffer_read}
  snap_t      snap_q[$];
  snap_t      mon_s;
  logic       rd_seen = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_seen <= read_strobe;

  // Monitor: compares every DUT response against the queued expectations
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_out: unexpected response %h", data_out);
      end else begin
        chk("data_out", {24'h0, data_out}, {24'h0, rd_q.pop_front()});
      end
    end
    if ((buffer_write | buffer_read) != '0) begin
      if (pulse_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fifo_pulse: unexpected bw=%b br=%b", buffer_write, buffer_read);
      end else begin
        chk("fifo_pulse", {28'h0, buffer_write, buffer_read}, {28'h0, pulse_q.pop_front()});
      end
    end
    while (snap_q.size() > 0) begin
      mon_s = snap_q.pop_front();
      case (mon_s.kind)
        0:       chk("interrupt", {31'h0, interrupt}, mon_s.exp);
        1:       chk("uart_clock_divide", uart_clock_divide, mon_s.exp);
        2:       chk("uart_data_write", {24'h0, uart_data_write}, mon_s.exp);
        default: chk("enable", {30'h0, enable}, mon_s.exp);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id = p; data_in = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] p, input logic [7:0] e);
    port_id = p; read_strobe = 1'b1;
    rd_q.push_back(e);
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic snap(input int k, input logic [31:0] e);
    snap_q.push_back('{kind: k, exp: e});
  endtask

  function automatic logic [7:0] reset_read(input int p);
    case (p)
      2:       return 8'h02;   // ch0 rx_half_full
      6, 14:   return 8'hC3;   // committed divisor high byte
      10:      return 8'h10;   // ch1 tx_half_full
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; port_id = 8'h00; data_in = 8'h00;
    read_strobe = 1'b0; write_strobe = 1'b0;
    uart_data_read = '0;
    rx_dp = 2'b00; rx_hf = 2'b01; rx_fl = 2'b00;
    tx_dp = 2'b00; tx_hf = 2'b10; tx_fl = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Reset state and full port sweep
    snap(0, 32'h0); snap(1, {DIVR, DIVR}); snap(2, 32'h0); snap(3, 32'h0);
    for (int p = 0; p <= 16; p++) rd(8'(p), reset_read(p));
    rd(8'hFF, 8'h00);

    // Atomic divisor update through the shadow
    wr(8'h05, 8'h34);
    snap(1, {DIVR, DIVR});
    wr(8'h06, 8'h12);
    snap(1, {DIVR, 16'h1234});
    rd(8'h05, 8'h34);
    rd(8'h06, 8'h12);
    rd(8'h0E, 8'hC3);

    // TX push on ch1, then overflow with tx_full
    pulse_q.push_back({2'b10, 2'b00});
    wr(8'h08, 8'hA5);
    snap(2, 32'hA5);
    tick();
    tx_fl = 2'b10;
    wr(8'h08, 8'h5C);
    snap(2, 32'h5C);
    tick();
    rd(8'h0C, 8'h08);
    rd(8'h0A, 8'h30);
    tx_fl = 2'b00;
    wr(8'h0C, 8'h08);
    rd(8'h0C, 8'h00);

    // RX data interrupt on ch0, latency and W1C clear
    wr(8'h03, 8'h01);
    rx_dp[0] = 1'b1;
    tick(); snap(0, 32'h0);
    tick(); snap(0, 32'h1);
    rd(8'h10, 8'h01);
    rd(8'h04, 8'h01);
    wr(8'h04, 8'h01);
    snap(0, 32'h1);
    tick(); snap(0, 32'h0);

    // W1C coinciding with a new rising edge: event wins
    rx_dp[0] = 1'b0; tick(); tick();
    rx_dp[0] = 1'b1; tick(); tick();
    snap(0, 32'h1);
    rx_dp[0] = 1'b0; tick(); tick();
    rx_dp[0] = 1'b1; port_id = 8'h04; data_in = 8'h01; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    snap(0, 32'h1);
    tick(); snap(0, 32'h1);
    rd(8'h04, 8'h01);

    // Held DATA read: three responses, a single pop pulse
    uart_data_read = 16'h775A;
    port_id = 8'h00; read_strobe = 1'b1;
    pulse_q.push_back({2'b00, 2'b01});
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back(8'h5A);
      tick();
    end
    read_strobe = 1'b0;
    tick(); tick();
    rx_dp[0] = 1'b0;
    tick();
    rd(8'h00, 8'h5A);
    tick(); tick();

    // TX drained event on ch1 and summary bit 1
    wr(8'h04, 8'h01);
    wr(8'h0B, 8'h04);
    tx_dp[1] = 1'b1; tick(); tick();
    tx_dp[1] = 1'b0;
    tick(); snap(0, 32'h0);
    tick(); snap(0, 32'h1);
    rd(8'h10, 8'h02);
    rd(8'h0C, 8'h04);
    wr(8'h0C, 8'hFF);
    tick(); snap(0, 32'h0);

    // CONTROL / enable and misc reads
    wr(8'h01, 8'h81);
    wr(8'h09, 8'h01);
    snap(3, 32'h3);
    rd(8'h01, 8'h81);
    rd(8'h09, 8'h01);
    rd(8'h07, 8'h00);
    rd(8'h03, 8'h01);
    rd(8'h0B, 8'h04);
    rd(8'h11, 8'h00);

    // Reset mid-operation with a DATA write in flight and a flag high
    rx_dp[0] = 1'b1; reset = 1'b1;
    port_id = 8'h00; data_in = 8'h99; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    snap(0, 32'h0); snap(1, {DIVR, DIVR}); snap(2, 32'h0); snap(3, 32'h0);
    rd(8'h04, 8'h00);
    rd(8'h05, 8'h00);
    rd(8'h02, 8'h03);
    repeat (3) tick();

    chk("rd_queue_drained", rd_q.size(), 32'd0);
    chk("pulse_queue_drained", pulse_q.size(), 32'd0);
    chk("snap_queue_drained", snap_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pb_uart_regs_mc.md
# pb_uart_regs_mc

Multi-channel PicoBlaze port-mapped register front end for up to NUM_CHANNELS UART/FIFO pairs. Each channel gets an 8-port window holding data, control, status, interrupt and baud-divisor registers. The block adds sticky write-1-to-clear interrupt sources, TX-overflow detection, atomic 16-bit divisor update and a global interrupt summary. It sits between the PicoBlaze I/O bus and the per-channel UART TX/RX FIFOs.

## Interface
- BASE_ADDRESS, 8'h00, first port of channel 0; must be 8-aligned
- NUM_CHANNELS, 2, number of channels (1..4); channel c window = BASE_ADDRESS + 8*c
- DIV_RESET, 16'h0000, reset value of every channel's divisor
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- port_id  in  8  PicoBlaze port address
- data_in  in  8  PicoBlaze write data
- data_out  out  8  registered read data
- read_strobe  in  1  PicoBlaze read strobe
- write_strobe  in  1  PicoBlaze write strobe
- interrupt  out  1  registered OR of all channels' masked pending bits
- buffer_write  out  NUM_CHANNELS  one-cycle TX FIFO push, per channel
- uart_data_write  out  8  TX data shared by all channels
- buffer_read  out  NUM_CHANNELS  one-cycle RX FIFO pop, per channel
- uart_data_read  in  8*NUM_CHANNELS  RX FIFO head; channel c at [8c+7:8c]
- rx_data_present, rx_half_full, rx_full  in  NUM_CHANNELS each  RX FIFO flags
- tx_data_present, tx_half_full, tx_full  in  NUM_CHANNELS each  TX FIFO flags
- enable  out  NUM_CHANNELS  CONTROL[0] of each channel
- uart_clock_divide  out  16*NUM_CHANNELS  committed divisor; channel c at [16c+15:16c]

## Operation
- Offsets within a window:
  - 0 DATA: W pushes TX; R pops RX.
  - 1 CONTROL: R/W 8 bits; bit0 = enable.
  - 2 STATUS: RO {2'b0, tx_full, tx_half_full, tx_data_present, rx_full, rx_half_full, rx_data_present}.
  - 3 IRQ_MASK: R/W, 4 bits.
  - 4 IRQ_PEND: R, W1C, 4 bits.
  - 5 DIV_LO: R/W shadow.
  - 6 DIV_HI: W commits {data_in, shadow}; R returns committed [15:8].
  - 7 reserved, reads 0.
- Port BASE_ADDRESS + 8*NUM_CHANNELS is IRQ_SUMMARY (RO): bit c = channel c has a masked pending bit. Every other port reads 8'h00.
- IRQ_PEND bits:
  - bit0: rx_data_present rising edge.
  - bit1: rx_full rising edge.
  - bit2: tx_data_present falling edge (TX drained).
  - bit3: TX overflow.
- Edges are taken against a registered copy of each flag.
- DATA write with tx_full=1: no buffer_write; sets IRQ_PEND[3]; uart_data_write is still updated.
- DATA read with rx_data_present=0: returns uart_data_read unchanged; no buffer_read pulse.
- W1C write coinciding with a new event on the same bit: the bit stays set (event wins).
- Reading DIV_LO returns the shadow, not the committed value.
- Reset values:
  - data_out, interrupt, buffer_write, buffer_read, uart_data_write, CONTROL, IRQ_MASK, IRQ_PEND, shadow: 0.
  - enable: 0.
  - uart_clock_divide: DIV_RESET per channel.
  - Edge-detect registers load the current flags on the first cycle after reset, so reset produces no spurious edges.

## Timing
- data_out is registered from the port_id decode every cycle, with no qualification by read_strobe. It is valid one cycle after port_id is stable, which meets the PicoBlaze 2-cycle port_id setup.
- buffer_write / buffer_read: exactly one cycle high, in the cycle after the qualifying strobe. A strobe held N cycles produces one pulse (rising-edge qualified).
- Register writes take effect at the clk edge that samples write_strobe.
- interrupt rises 2 cycles after the flag edge: one cycle to set IRQ_PEND, one for the output register.
- interrupt falls one cycle after the clearing write.
- Divisor commit: uart_clock_divide changes in the cycle after the DIV_HI write strobe, with all 16 bits updating together.
- Reset mid-operation: any pulse in flight is dropped; all state returns to its reset value on the next edge.

## Structure
- Shared package pb_uart_regs_pkg holds:
  - register offsets 0..7 and CHAN_STRIDE = 8;
  - IRQ bit indices (IRQ_RX_DATA, IRQ_RX_FULL, IRQ_TX_EMPTY, IRQ_TX_OVF);
  - STATUS bit positions.
- Sub-module pb_uart_regs_chan, one instance per channel (generate loop), contains:
  - CONTROL, IRQ mask/pending, shadow and divisor registers;
  - edge detection and strobe pulse logic;
  - an 8-bit combinational read value and a pending-masked output.
- Top level handles address decode, the read mux, data_out, IRQ_SUMMARY and interrupt.

## Test plan
- Reset, then read ports 0x00..0x10 (NUM_CHANNELS=2): STATUS reflects the flags; all other ports return 0x00; interrupt=0; uart_clock_divide=DIV_RESET.
- Write 0x34 to port 0x05, then 0x12 to port 0x06: uart_clock_divide[15:0] stays DIV_RESET until the DIV_HI write, then becomes 16'h1234 in one step; reading port 0x05 returns 0x34.
- Write 0xA5 to port 0x08 with tx_full[1]=0: buffer_write=2'b10 for one cycle and uart_data_write=0xA5. Repeat with tx_full[1]=1: no pulse, and port 0x0C reads 0x08.
- Set IRQ_MASK ch0 = 0x1 and raise rx_data_present[0]: interrupt=1 two cycles later; port 0x10 reads 0x01. Write 0x01 to port 0x04 with no new edge: interrupt=0 next cycle.
- W1C of port 0x04 bit0 issued in the same cycle as an rx_data_present[0] rising edge: the pending bit remains 1 and interrupt stays 1.
- Read port 0x00 with rx_data_present[0]=1 and uart_data_read[7:0]=0x5A: data_out=0x5A and a single buffer_read[0] pulse, even with read_strobe held 3 cycles. Repeat with rx_data_present[0]=0: no pulse.
